// File: rtl/image_read_seq.sv
// image_read_seq: per-layer sequencer for an image_read block.
// Accepts a layer descriptor, writes its four config words to image_read,
// then issues one 'next' pulse per image pass, waiting for each pass to end
// with an image_last handshake before issuing the next one. Every output is
// registered: the output registers are loaded from the next-state view, so
// an output becomes visible in the same cycle as the state that owns it.
module image_read_seq #(
    parameter int CFG_DWIDTH  = 32,
    parameter int CFG_AWIDTH  = 5,
    parameter int ADDR_IMG_W  = 1,
    parameter int ADDR_IMG_DH = 2,
    parameter int ADDR_PAD    = 3,
    parameter int ADDR_CONV   = 4,
    parameter int PASS_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    // Layer command: {conv, pad, img_dh, img_w}, img_w in the LSBs.
    input  logic [4*CFG_DWIDTH-1:0] cmd_data,
    input  logic [PASS_WIDTH-1:0]   cmd_passes,
    input  logic                    cmd_val,
    output logic                    cmd_rdy,
    // Config write port towards image_read.
    output logic [CFG_DWIDTH-1:0]   cfg_data,
    output logic [CFG_AWIDTH-1:0]   cfg_addr,
    output logic                    cfg_valid,
    // Pass control and monitored image_read output handshake.
    output logic                    next,
    input  logic                    image_last,
    input  logic                    image_val,
    input  logic                    image_rdy,
    // Status.
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    state_t                  state_q,     state_d;
    logic [1:0]              cfg_idx_q,   cfg_idx_d;
    logic [PASS_WIDTH-1:0]   pass_cnt_q,  pass_cnt_d;
    logic [4*CFG_DWIDTH-1:0] desc_q,      desc_d;
    logic [PASS_WIDTH-1:0]   passes_q,    passes_d;

    logic                    cmd_rdy_q,   cmd_rdy_d;
    logic                    busy_q,      busy_d;
    logic                    cfg_valid_q, cfg_valid_d;
    logic [CFG_DWIDTH-1:0]   cfg_data_q,  cfg_data_d;
    logic [CFG_AWIDTH-1:0]   cfg_addr_q,  cfg_addr_d;
    logic                    next_q,      next_d;
    logic                    done_q,      done_d;

    // A pass ends only on a complete last-beat handshake.
    logic pass_end;
    assign pass_end = image_val && image_rdy && image_last;

    // Config address for write slot 0..3 (img_w, img_dh, pad, conv).
    function automatic logic [CFG_AWIDTH-1:0] slot_addr(input logic [1:0] idx);
        logic [CFG_AWIDTH-1:0] addr;
        case (idx)
            2'd0:    addr = CFG_AWIDTH'(ADDR_IMG_W);
            2'd1:    addr = CFG_AWIDTH'(ADDR_IMG_DH);
            2'd2:    addr = CFG_AWIDTH'(ADDR_PAD);
            default: addr = CFG_AWIDTH'(ADDR_CONV);
        endcase
        return addr;
    endfunction

    // Config word for write slot 0..3, taken from the descriptor LSBs up.
    function automatic logic [CFG_DWIDTH-1:0] slot_data(input logic [1:0]              idx,
                                                        input logic [4*CFG_DWIDTH-1:0] desc);
        logic [CFG_DWIDTH-1:0] word;
        case (idx)
            2'd0:    word = desc[0*CFG_DWIDTH +: CFG_DWIDTH];
            2'd1:    word = desc[1*CFG_DWIDTH +: CFG_DWIDTH];
            2'd2:    word = desc[2*CFG_DWIDTH +: CFG_DWIDTH];
            default: word = desc[3*CFG_DWIDTH +: CFG_DWIDTH];
        endcase
        return word;
    endfunction

    // Next-state, counters and next values of the registered outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned; a missing default here infers a latch.
        state_d     = state_q;
        cfg_idx_d   = cfg_idx_q;
        pass_cnt_d  = pass_cnt_q;
        desc_d      = desc_q;
        passes_d    = passes_q;
        cfg_valid_d = 1'b0;
        next_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_val && cmd_rdy_q) begin
                    desc_d      = cmd_data;
                    passes_d    = cmd_passes;
                    pass_cnt_d  = '0;
                    cfg_idx_d   = 2'd0;
                    cfg_valid_d = 1'b1;
                    state_d     = S_CFG;
                end
            end

            S_CFG: begin
                if (cfg_idx_q == 2'd3) begin
                    // Last config word is on the bus this cycle.
                    if (passes_q != '0) begin
                        next_d  = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end else begin
                    cfg_idx_d   = cfg_idx_q + 2'd1;
                    cfg_valid_d = 1'b1;
                end
            end

            S_ISSUE: begin
                // 'next' is visible this cycle; the pass is now running.
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (pass_end) begin
                    pass_cnt_d = pass_cnt_q + 1'b1;
                    if (pass_cnt_d == passes_q) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        next_d  = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_rdy_d  = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
        // Config bus is forced to zero whenever no write is presented.
        cfg_addr_d = cfg_valid_d ? slot_addr(cfg_idx_d)         : '0;
        cfg_data_d = cfg_valid_d ? slot_data(cfg_idx_d, desc_d) : '0;
    end

    // State register with synchronous reset; abandons any layer in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the pre-edge values regardless of order.
        if (rst) begin
            state_q     <= S_IDLE;
            cfg_idx_q   <= 2'd0;
            pass_cnt_q  <= '0;
            desc_q      <= '0;
            passes_q    <= '0;
            cmd_rdy_q   <= 1'b1;
            busy_q      <= 1'b0;
            cfg_valid_q <= 1'b0;
            cfg_data_q  <= '0;
            cfg_addr_q  <= '0;
            next_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_idx_q   <= cfg_idx_d;
            pass_cnt_q  <= pass_cnt_d;
            desc_q      <= desc_d;
            passes_q    <= passes_d;
            cmd_rdy_q   <= cmd_rdy_d;
            busy_q      <= busy_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_data_q  <= cfg_data_d;
            cfg_addr_q  <= cfg_addr_d;
            next_q      <= next_d;
            done_q      <= done_d;
        end
    end

    assign cmd_rdy   = cmd_rdy_q;
    assign busy      = busy_q;
    assign cfg_valid = cfg_valid_q;
    assign cfg_data  = cfg_data_q;
    assign cfg_addr  = cfg_addr_q;
    assign next      = next_q;
    assign done      = done_q;

endmodule

// File: tb/tb_image_read_seq.sv
// Self-checking bench for image_read_seq. A behavioural model derives each
// layer's expected output trace from the descriptor: four config writes in
// fixed address order, then one 'next' per pass, each following a completed
// last-beat handshake, then a single 'done' and a return to ready.
module tb_image_read_seq;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int PW = 16;

    // Expected address per config slot (design defaults).
    localparam logic [AW-1:0] EXP_ADDR [4] = '{5'd1, 5'd2, 5'd3, 5'd4};

    // Status vector order: {cmd_rdy, busy, cfg_valid, next, done}.
    localparam logic [4:0] ST_IDLE = 5'b10000;
    localparam logic [4:0] ST_CFG  = 5'b01100;
    localparam logic [4:0] ST_NEXT = 5'b01010;
    localparam logic [4:0] ST_RUN  = 5'b01000;
    localparam logic [4:0] ST_DONE = 5'b01001;

    logic            clk = 1'b0;
    logic            rst;
    logic [4*DW-1:0] cmd_data;
    logic [PW-1:0]   cmd_passes;
    logic            cmd_val;
    logic            cmd_rdy;
    logic [DW-1:0]   cfg_data;
    logic [AW-1:0]   cfg_addr;
    logic            cfg_valid;
    logic            next;
    logic            image_last;
    logic            image_val;
    logic            image_rdy;
    logic            busy;
    logic            done;

    int total = 0;
    int bad   = 0;

    image_read_seq dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_data   (cmd_data),
        .cmd_passes (cmd_passes),
        .cmd_val    (cmd_val),
        .cmd_rdy    (cmd_rdy),
        .cfg_data   (cfg_data),
        .cfg_addr   (cfg_addr),
        .cfg_valid  (cfg_valid),
        .next       (next),
        .image_last (image_last),
        .image_val  (image_val),
        .image_rdy  (image_rdy),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] stat();
        return {cmd_rdy, busy, cfg_valid, next, done};
    endfunction

    // Advance one clock; sample and drive 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a random image handshake that is never a complete last beat.
    task automatic drive_noise();
        logic [2:0] r;
        r = 3'($urandom_range(0, 6));
        {image_val, image_rdy, image_last} = r;
    endtask

    // Runs one full layer and compares every cycle against the expected trace.
    // mode 0: random gaps with noise; mode 1: 5-cycle stall with image_rdy=0.
    task automatic run_layer(input logic [4*DW-1:0] desc, input int passes,
                             input bit hold_cmd, input int mode, input string name);
        int waits;
        total++;
        if (cmd_rdy !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready got=%b exp=1", name, cmd_rdy);
        end
        cmd_data   = desc;
        cmd_passes = PW'(passes);
        cmd_val    = 1'b1;
        step();
        if (hold_cmd) begin
            // Busy-time command with a different descriptor must be ignored.
            cmd_data   = {$urandom, $urandom, $urandom, $urandom};
            cmd_passes = PW'($urandom);
        end else begin
            cmd_val = 1'b0;
        end

        for (int i = 0; i < 4; i++) begin
            total++;
            if (stat() !== ST_CFG || cfg_addr !== EXP_ADDR[i] ||
                cfg_data !== desc[i*DW +: DW]) begin
                bad++;
                $display("FAIL %s_cfg%0d got st=%b a=%0d d=%h exp st=%b a=%0d d=%h",
                         name, i, stat(), cfg_addr, cfg_data, ST_CFG, EXP_ADDR[i],
                         desc[i*DW +: DW]);
            end
            // Handshakes before the first pass starts must not count.
            {image_val, image_rdy, image_last} = 3'($urandom_range(0, 7));
            step();
        end

        for (int p = 0; p < passes; p++) begin
            total++;
            if (stat() !== ST_NEXT || cfg_addr !== '0 || cfg_data !== '0) begin
                bad++;
                $display("FAIL %s_next%0d got st=%b a=%0d d=%h exp st=%b a=0 d=0",
                         name, p, stat(), cfg_addr, cfg_data, ST_NEXT);
            end
            // A complete handshake in the 'next' cycle itself is ignored.
            {image_val, image_rdy, image_last} = 3'($urandom_range(0, 7));
            step();
            waits = (mode == 1) ? 5 : int'($urandom_range(0, 4));
            for (int w = 0; w <= waits; w++) begin
                total++;
                if (stat() !== ST_RUN || cfg_addr !== '0 || cfg_data !== '0) begin
                    bad++;
                    $display("FAIL %s_wait%0d_%0d got st=%b a=%0d d=%h exp st=%b a=0 d=0",
                             name, p, w, stat(), cfg_addr, cfg_data, ST_RUN);
                end
                if (w == waits) begin
                    {image_val, image_rdy, image_last} = 3'b111;
                end else if (mode == 1) begin
                    {image_val, image_rdy, image_last} = 3'b101;
                end else begin
                    drive_noise();
                end
                step();
            end
            {image_val, image_rdy, image_last} = 3'b000;
        end

        total++;
        if (stat() !== ST_DONE || cfg_addr !== '0 || cfg_data !== '0) begin
            bad++;
            $display("FAIL %s_done got st=%b a=%0d d=%h exp st=%b a=0 d=0",
                     name, stat(), cfg_addr, cfg_data, ST_DONE);
        end
        cmd_val = 1'b0;
        step();
        total++;
        if (stat() !== ST_IDLE || cfg_addr !== '0 || cfg_data !== '0) begin
            bad++;
            $display("FAIL %s_idle got st=%b a=%0d d=%h exp st=%b a=0 d=0",
                     name, stat(), cfg_addr, cfg_data, ST_IDLE);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        cmd_val    = 1'b0;
        cmd_data   = '0;
        cmd_passes = '0;
        {image_val, image_rdy, image_last} = 3'b000;
        repeat (3) step();
        rst = 1'b0;
        total++;
        if (stat() !== ST_IDLE || cfg_addr !== '0 || cfg_data !== '0) begin
            bad++;
            $display("FAIL reset got st=%b a=%0d d=%h exp st=%b a=0 d=0",
                     stat(), cfg_addr, cfg_data, ST_IDLE);
        end
        step();
    endtask

    task automatic test_cfg_order();
        run_layer({32'h00020001, 32'h01010101, 32'h00070004, 32'd9}, 3, 1'b0, 0, "scn1");
    endtask

    task automatic test_zero_passes();
        run_layer({$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 0, "zero");
    endtask

    task automatic test_stall();
        run_layer({$urandom, $urandom, $urandom, $urandom}, 2, 1'b0, 1, "stall");
    endtask

    task automatic test_busy_cmd();
        run_layer({$urandom, $urandom, $urandom, $urandom}, 2, 1'b1, 0, "busy1");
        run_layer({$urandom, $urandom, $urandom, $urandom}, 1, 1'b0, 0, "busy2");
    endtask

    task automatic test_reset_mid();
        // Reset while config write 2 is on the bus.
        cmd_data   = {$urandom, $urandom, $urandom, $urandom};
        cmd_passes = 16'd2;
        cmd_val    = 1'b1;
        step();
        cmd_val = 1'b0;
        step();
        total++;
        if (cfg_addr !== EXP_ADDR[1] || cfg_valid !== 1'b1) begin
            bad++;
            $display("FAIL rst_cfg_pre got v=%b a=%0d exp v=1 a=%0d", cfg_valid, cfg_addr,
                     EXP_ADDR[1]);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (stat() !== ST_IDLE || cfg_addr !== '0 || cfg_data !== '0) begin
                bad++;
                $display("FAIL rst_cfg_after%0d got st=%b a=%0d d=%h exp st=%b a=0 d=0",
                         c, stat(), cfg_addr, cfg_data, ST_IDLE);
            end
            step();
        end

        // Reset while waiting for a pass to finish, with a last beat present.
        cmd_passes = 16'd2;
        cmd_val    = 1'b1;
        step();
        cmd_val = 1'b0;
        repeat (5) step();
        total++;
        if (stat() !== ST_RUN) begin
            bad++;
            $display("FAIL rst_wait_pre got st=%b exp st=%b", stat(), ST_RUN);
        end
        rst = 1'b1;
        {image_val, image_rdy, image_last} = 3'b111;
        step();
        rst = 1'b0;
        {image_val, image_rdy, image_last} = 3'b000;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (stat() !== ST_IDLE || cfg_addr !== '0 || cfg_data !== '0) begin
                bad++;
                $display("FAIL rst_wait_after%0d got st=%b a=%0d d=%h exp st=%b a=0 d=0",
                         c, stat(), cfg_addr, cfg_data, ST_IDLE);
            end
            step();
        end
        run_layer({$urandom, $urandom, $urandom, $urandom}, 1, 1'b0, 0, "rst_recover");
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            run_layer({$urandom, $urandom, $urandom, $urandom},
                      int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 0,
                      $sformatf("rnd%0d", k));
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    initial begin
        test_reset();
        test_cfg_order();
        test_zero_passes();
        test_stall();
        test_busy_cmd();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/image_read_seq.md
IMAGE_READ_SEQ -- requirements
Module: image_read_seq

Interface
REQ-001 Parameter CFG_DWIDTH, default 32: width of the config data bus.
REQ-002 Parameter CFG_AWIDTH, default 5: width of the config address bus.
REQ-003 Parameters ADDR_IMG_W / ADDR_IMG_DH / ADDR_PAD / ADDR_CONV, defaults 1 / 2 / 3 / 4: image_read config register addresses.
REQ-004 Parameter PASS_WIDTH, default 16: width of the pass counter and cmd_passes.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 cmd_data  in  4*CFG_DWIDTH  layer descriptor {conv, pad, img_dh, img_w}; img_w in the LSBs.
REQ-008 cmd_passes  in  PASS_WIDTH  number of image passes (next pulses) for the layer.
REQ-009 cmd_val  in  1  command valid.
REQ-010 cmd_rdy  out  1  command ready; high only in IDLE.
REQ-011 cfg_data  out  CFG_DWIDTH  config word to image_read.
REQ-012 cfg_addr  out  CFG_AWIDTH  config address to image_read.
REQ-013 cfg_valid  out  1  config write strobe.
REQ-014 next  out  1  one-cycle pass start pulse to image_read.
REQ-015 image_last / image_val / image_rdy  in  1 each  monitored image_read output handshake.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 done  out  1  one-cycle pulse at layer completion.

Function
REQ-018 The FSM SHALL have the states IDLE, CFG, ISSUE, WAIT and DONE.
REQ-019 All outputs SHALL be registered.
REQ-020 Command acceptance: cmd_val && cmd_rdy at an edge latches cmd_data and cmd_passes, clears the pass count and the cfg index, and moves to CFG.
REQ-021 CFG: cfg_valid=1 for exactly 4 consecutive cycles, starting the cycle after acceptance.
REQ-022 CFG write order: (ADDR_IMG_W, word0), (ADDR_IMG_DH, word1), (ADDR_PAD, word2), (ADDR_CONV, word3).
REQ-023 After the 4th write, the FSM SHALL go to ISSUE if latched passes != 0, otherwise to DONE.
REQ-024 ISSUE: next=1 for exactly one cycle, then move to WAIT.
REQ-025 WAIT: a pass completes on image_val && image_rdy && image_last; the pass count increments by 1.
REQ-026 On pass completion, if the new count == passes, go to DONE; else go to ISSUE.
REQ-027 next SHALL rise no earlier than 1 cycle after the completing handshake.
REQ-028 A last-handshake outside WAIT SHALL be ignored: the pass count SHALL NOT change.
REQ-029 image_val/image_rdy/image_last without image_last, or without both val and rdy, SHALL NOT count.
REQ-030 DONE: done=1 for one cycle, then return to IDLE; cmd_rdy=1 the following cycle.
REQ-031 cmd_val while busy SHALL be ignored, and the latched descriptor SHALL stay stable.
REQ-032 The pass count SHALL use PASS_WIDTH bits with no wrap; the maximum is 2^PASS_WIDTH-1 passes.
REQ-033 cfg_data and cfg_addr SHALL be 0 whenever cfg_valid=0.
REQ-034 Command-to-first-next latency SHALL be 5 cycles (4 config cycles + 1).

Reset
REQ-035 rst SHALL return the FSM to IDLE in the following cycle from any state and abandon the layer in progress.
REQ-036 Reset values: cmd_rdy=1 and busy=0.
REQ-037 Reset values: cfg_valid=0, cfg_data=0 and cfg_addr=0.
REQ-038 Reset values: next=0, done=0 and pass count=0.
REQ-039 No partial cfg write or next pulse SHALL occur in the cycle after rst is asserted.

Verification
REQ-040 Scenario 1: cmd passes=3, words {0x00020001, 0x01010101, 0x00070004, 9} -> cfg writes (1,9), (2,0x00070004), (3,0x01010101), (4,0x00020001) on cycles 1-4; next on cycle 5.
REQ-041 Scenario 2: 3 passes, each ending with an image_last handshake -> exactly 3 next pulses, then done=1 once, then cmd_rdy=1.
REQ-042 Scenario 3: passes=0 -> 4 cfg writes, no next, done on cycle 5.
REQ-043 Scenario 4: image_last=1 with image_rdy=0 for 5 cycles in WAIT -> no count; then image_rdy=1 -> pass counted.
REQ-044 Scenario 5: cmd_val held high during a layer -> no new acceptance; the 2nd command is accepted only after done.
REQ-045 Scenario 6: rst pulsed during CFG write 2 and again in WAIT -> next cycle IDLE, all outputs at reset values, no extra next/done.
